// File: rtl/regfile_wb_scheduler.sv
// Register-file writeback scheduler: round-robin arbitration between ALU and LSU
// writeback ports, a registered write stage, and a per-register busy scoreboard.
module regfile_wb_scheduler #(
   parameter  int XLEN = 32,
   parameter  int NREG = 32,
   localparam int AW   = $clog2(NREG)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            req0_valid,
   input  logic [AW-1:0]   req0_rd,
   input  logic [XLEN-1:0] req0_wdata,
   output logic            req0_ready,
   input  logic            req1_valid,
   input  logic [AW-1:0]   req1_rd,
   input  logic [XLEN-1:0] req1_wdata,
   output logic            req1_ready,
   output logic            rf_we,
   output logic [AW-1:0]   rf_rd,
   output logic [XLEN-1:0] rf_wdata,
   input  logic            issue_valid,
   input  logic [AW-1:0]   issue_rs1,
   input  logic [AW-1:0]   issue_rs2,
   input  logic [AW-1:0]   issue_rd,
   output logic            issue_stall,
   output logic            idle
);

   logic            last1_q, last1_d;
   logic            rf_we_q;
   logic [AW-1:0]   rf_rd_q;
   logic [XLEN-1:0] rf_wdata_q;
   logic [NREG-1:0] busy_q, busy_d;

   logic            gnt0, gnt1, hs;
   logic [AW-1:0]   sel_rd;
   logic [XLEN-1:0] sel_wdata;
   logic            issue_go;

   always_comb begin
      gnt0      = 1'b0;
      gnt1      = 1'b0;
      // last1_q=1 means port 1 won the previous handshake, so port 0 has priority
      if (!rst) begin
         gnt0 = req0_valid && (!req1_valid || last1_q);
         gnt1 = req1_valid && (!req0_valid || !last1_q);
      end
      hs        = gnt0 || gnt1;
      sel_rd    = gnt1 ? req1_rd    : req0_rd;
      sel_wdata = gnt1 ? req1_wdata : req0_wdata;
      last1_d   = last1_q;
      if (gnt0) begin
         last1_d = 1'b0;
      end else if (gnt1) begin
         last1_d = 1'b1;
      end
   end

   assign issue_stall = issue_valid &&
                        (busy_q[issue_rs1] || busy_q[issue_rs2] || busy_q[issue_rd]);
   assign issue_go    = issue_valid && !issue_stall && (issue_rd != '0);

   always_comb begin
      busy_d = busy_q;
      if (rf_we_q) begin
         busy_d[rf_rd_q] = 1'b0;
      end
      // applied after the clear so a same-edge set keeps the register busy
      if (issue_go) begin
         busy_d[issue_rd] = 1'b1;
      end
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         last1_q    <= 1'b1;
         rf_we_q    <= 1'b0;
         rf_rd_q    <= '0;
         rf_wdata_q <= '0;
         busy_q     <= '0;
      end else begin
         last1_q    <= last1_d;
         rf_we_q    <= hs && (sel_rd != '0);
         busy_q     <= busy_d;
         if (hs) begin
            rf_rd_q    <= sel_rd;
            rf_wdata_q <= sel_wdata;
         end
      end
   end

   assign req0_ready = gnt0;
   assign req1_ready = gnt1;
   assign rf_we      = rf_we_q;
   assign rf_rd      = rf_rd_q;
   assign rf_wdata   = rf_wdata_q;
   assign idle       = (busy_q == '0) && !rf_we_q;

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Scoreboard bench for regfile_wb_scheduler: a cycle-level reference model predicts
// grants, stalls and idle; accepted writes are queued and checked by a separate monitor.
module tb_regfile_wb_scheduler;

   localparam int XLEN = 32;
   localparam int NREG = 32;

   logic            clk = 1'b0;
   logic            rst = 1'b0;
   logic            req0_valid = 1'b0, req1_valid = 1'b0;
   logic [4:0]      req0_rd = '0, req1_rd = '0;
   logic [XLEN-1:0] req0_wdata = '0, req1_wdata = '0;
   logic            req0_ready, req1_ready;
   logic            rf_we;
   logic [4:0]      rf_rd;
   logic [XLEN-1:0] rf_wdata;
   logic            issue_valid = 1'b0;
   logic [4:0]      issue_rs1 = '0, issue_rs2 = '0, issue_rd = '0;
   logic            issue_stall, idle;

   regfile_wb_scheduler #(.XLEN(XLEN), .NREG(NREG)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_rd(req0_rd), .req0_wdata(req0_wdata), .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_rd(req1_rd), .req1_wdata(req1_wdata), .req1_ready(req1_ready),
      .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata),
      .issue_valid(issue_valid), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2), .issue_rd(issue_rd),
      .issue_stall(issue_stall), .idle(idle)
   );

   always #5 clk = ~clk;

   typedef struct { logic [4:0] rd; logic [XLEN-1:0] d; } wr_t;
   wr_t wq[$];

   int checks = 0;
   int errors = 0;
   bit mon_en = 0;

   // reference state: busy set, who was granted last, and the write due next cycle
   bit       mbusy [NREG];
   bit       mlast1;
   bit       mwe;
   int       mrd;
   bit       g0, g1;

   task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit model_idle();
      for (int i = 0; i < NREG; i++) if (mbusy[i]) return 1'b0;
      return !mwe;
   endfunction

   task automatic cycle(input bit r,
                        input bit v0, input int a0, input logic [XLEN-1:0] d0,
                        input bit v1, input int a1, input logic [XLEN-1:0] d1,
                        input bit iv, input int s1, input int s2, input int ird);
      bit st;
      @(negedge clk);
      rst = r;
      req0_valid = v0; req0_rd = 5'(a0); req0_wdata = d0;
      req1_valid = v1; req1_rd = 5'(a1); req1_wdata = d1;
      issue_valid = iv; issue_rs1 = 5'(s1); issue_rs2 = 5'(s2); issue_rd = 5'(ird);
      #1;
      g0 = !r && v0 && (!v1 || mlast1);
      g1 = !r && v1 && (!v0 || !mlast1);
      st = iv && (mbusy[s1] || mbusy[s2] || mbusy[ird]);
      chk("req0_ready", {31'b0, req0_ready}, {31'b0, g0});
      chk("req1_ready", {31'b0, req1_ready}, {31'b0, g1});
      chk("issue_stall", {31'b0, issue_stall}, {31'b0, st});
      chk("idle", {31'b0, idle}, {31'b0, model_idle()});
      if (r) begin
         foreach (mbusy[i]) mbusy[i] = 1'b0;
         mlast1 = 1'b1;
         mwe    = 1'b0;
         wq.delete();
         mon_en = 1'b1;
      end else begin
         if (mwe) mbusy[mrd] = 1'b0;
         if (iv && !st && ird != 0) mbusy[ird] = 1'b1;
         mwe = 1'b0;
         if (g0 || g1) begin
            mlast1 = g1;
            if ((g1 ? a1 : a0) != 0) begin
               mwe = 1'b1;
               mrd = g1 ? a1 : a0;
               wq.push_back('{rd: 5'(mrd), d: (g1 ? d1 : d0)});
            end
         end
      end
   endtask

   task automatic nop();
      cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic do_reset();
      cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      @(posedge clk); #1;
      chk("rst_rf_rd", {27'b0, rf_rd}, 32'h0);
      chk("rst_rf_wdata", rf_wdata, 32'h0);
   endtask

   // monitor: every accepted write with rd!=0 must appear on the write port next cycle
   initial begin
      wr_t e;
      forever begin
         @(posedge clk); #1;
         if (mon_en) begin
            chk("rf_we", {31'b0, rf_we}, {31'b0, (wq.size() > 0)});
            if (wq.size() > 0) begin
               e = wq.pop_front();
               if (rf_we === 1'b1) begin
                  chk("rf_rd", {27'b0, rf_rd}, {27'b0, e.rd});
                  chk("rf_wdata", rf_wdata, e.d);
               end
            end
         end
      end
   end

   initial begin
      bit h0, h1;
      int h0rd, h1rd;
      logic [XLEN-1:0] h0d, h1d;
      mlast1 = 1'b1; mwe = 1'b0; mrd = 0;
      foreach (mbusy[i]) mbusy[i] = 1'b0;

      do_reset();
      cycle(0, 1, 5, 32'h11111111, 0, 0, 0, 0, 0, 0, 0);
      nop(); nop();

      do_reset();
      cycle(0, 1, 3, 32'hA, 1, 4, 32'hB, 0, 0, 0, 0);
      cycle(0, 0, 0, 0, 1, 4, 32'hB, 0, 0, 0, 0);
      nop(); nop();

      cycle(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 7);
      cycle(0, 0, 0, 0, 0, 0, 0, 1, 7, 0, 0);
      cycle(0, 0, 0, 0, 1, 7, 32'h77777777, 1, 7, 0, 0);
      cycle(0, 0, 0, 0, 0, 0, 0, 1, 7, 0, 0);
      cycle(0, 0, 0, 0, 0, 0, 0, 1, 7, 0, 0);

      cycle(0, 1, 0, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0);
      nop(); nop();

      cycle(0, 1, 9, 32'h99, 0, 0, 0, 0, 0, 0, 0);
      cycle(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 9);
      cycle(0, 0, 0, 0, 0, 0, 0, 1, 0, 9, 0);
      cycle(0, 0, 0, 0, 0, 0, 0, 1, 1, 2, 9);

      cycle(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 3);
      cycle(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 4);
      cycle(0, 1, 3, 32'h33, 0, 0, 0, 0, 0, 0, 0);
      cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      cycle(0, 0, 0, 0, 0, 0, 0, 1, 3, 4, 9);
      nop();

      h0 = 0; h1 = 0; h0rd = 0; h1rd = 0; h0d = '0; h1d = '0;
      for (int n = 0; n < 3000; n++) begin
         if (!h0 && $urandom_range(0, 2) == 0) begin
            h0 = 1; h0rd = $urandom_range(0, 7); h0d = $urandom;
         end
         if (!h1 && $urandom_range(0, 2) == 0) begin
            h1 = 1; h1rd = $urandom_range(0, 7); h1d = $urandom;
         end
         cycle(($urandom_range(0, 199) == 0), h0, h0rd, h0d, h1, h1rd, h1d,
               $urandom_range(0, 1) == 1, $urandom_range(0, 7), $urandom_range(0, 7),
               $urandom_range(0, 7));
         if (g0) h0 = 0;
         if (g1) h1 = 0;
      end
      nop(); nop(); nop();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
